// File: rtl/apb_slave_mem_pkg.sv
// Shared types and constants for the APB memory completer.
//   apb_slv_state_t   : completer FSM states
//   APB_SLV_BASE_ADDR : window base, also used by the master's psel[0] decode
//   clog2_min1        : index width helper that never returns 0
package apb_slave_mem_pkg;

  typedef enum logic {
    APB_S_IDLE   = 1'b0,
    APB_S_ACCESS = 1'b1
  } apb_slv_state_t;

  localparam logic [31:0] APB_SLV_BASE_ADDR = 32'h0002_F000;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_slave_mem_sram.sv
// apb_sram: DEPTH_WORDS x DATA_WIDTH storage, one synchronous write port and
// one synchronous read port. No reset; contents survive rst.
//   clk                : rising-edge clock
//   we, waddr, wdata   : write port
//   re, raddr, rdata   : read port, rdata updates only when re=1
module apb_sram
  import apb_slave_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int DATA_WIDTH  = 32,
  parameter int IDX_W       = clog2_min1(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB3 completer with word-addressed memory, programmable
// wait states, range/alignment error responses and a sticky protocol checker.
//   clk, rst             : clock, synchronous active-high reset
//   psel, penable        : APB select / access phase
//   pwrite, paddr, pwdata: APB request
//   prdata, pready       : registered read data / transfer complete
//   pslverr              : registered error response (qualified by pready)
//   proto_err            : sticky protocol-violation flag
//   xfer_cnt             : completed transfers (OK + error), wrapping
module apb_slave_mem
  import apb_slave_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(APB_SLV_BASE_ADDR),
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  proto_err,
  output logic [15:0]           xfer_cnt
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int SHIFT  = $clog2(BYTES);
  localparam int IDX_W  = clog2_min1(DEPTH_WORDS);
  localparam int WCNT_W = clog2_min1(WAIT_CYCLES + 1);

  // Range bounds carried one bit wider so BASE+window cannot wrap.
  localparam logic [ADDR_WIDTH:0]   LO_X       = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0]   HI_X       = LO_X + (ADDR_WIDTH+1)'(DEPTH_WORDS * BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [WCNT_W-1:0]     WCNT_INIT  = WCNT_W'(WAIT_CYCLES);
  localparam logic                  NO_WAIT    = (WAIT_CYCLES == 0);

  apb_slv_state_t state, state_d;

  logic [WCNT_W-1:0]     wcnt;
  logic [ADDR_WIDTH-1:0] addr_l;
  logic [DATA_WIDTH-1:0] wdata_l;
  logic [IDX_W-1:0]      idx_l;
  logic                  wr_l, bad_l;
  logic                  rd_sel;   // 1: prdata shows the sram read register, 0: forced to zero
  logic [DATA_WIDTH-1:0] sram_rdata;

  // Request decode
  logic             in_range, aligned, bad;
  logic [IDX_W-1:0] idx;

  assign in_range = ({1'b0, paddr} >= LO_X) && ({1'b0, paddr} < HI_X);
  assign aligned  = (paddr & ALIGN_MASK) == '0;
  assign bad      = !in_range || !aligned;
  assign idx      = IDX_W'((paddr - BASE_ADDR) >> SHIFT);

  // Anything moving under an open transfer aborts it.
  logic viol;
  assign viol = !psel || !penable || (paddr != addr_l) ||
                (pwrite != wr_l) || (pwdata != wdata_l);

  // Control decode
  logic do_setup, do_wait, do_done, do_abort, idle_err;

  always_comb begin
    state_d  = state;
    do_setup = 1'b0;
    do_wait  = 1'b0;
    do_done  = 1'b0;
    do_abort = 1'b0;
    idle_err = 1'b0;
    case (state)
      APB_S_IDLE: begin
        if (psel && !penable) begin
          do_setup = 1'b1;
          state_d  = APB_S_ACCESS;
        end else if (penable) begin
          idle_err = 1'b1;
        end
      end
      APB_S_ACCESS: begin
        if (viol) begin
          do_abort = 1'b1;
          state_d  = APB_S_IDLE;
        end else if (pready) begin
          do_done = 1'b1;
          state_d = APB_S_IDLE;
        end else begin
          do_wait = 1'b1;
        end
      end
      default: state_d = APB_S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= APB_S_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      addr_l    <= '0;
      wdata_l   <= '0;
      idx_l     <= '0;
      wr_l      <= 1'b0;
      bad_l     <= 1'b0;
      rd_sel    <= 1'b0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      proto_err <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      if (do_setup) begin
        addr_l  <= paddr;
        wdata_l <= pwdata;
        idx_l   <= idx;
        wr_l    <= pwrite;
        bad_l   <= bad;
        wcnt    <= WCNT_INIT;
        // Good writes leave prdata alone; good reads and all errors reload it.
        if (bad)          rd_sel <= 1'b0;
        else if (!pwrite) rd_sel <= 1'b1;
        pready  <= NO_WAIT;
        pslverr <= bad && NO_WAIT;
      end
      if (do_wait) begin
        wcnt <= wcnt - 1'b1;
        if (wcnt == WCNT_W'(1)) begin
          pready  <= 1'b1;
          pslverr <= bad_l;
        end
      end
      if (do_done) begin
        xfer_cnt <= xfer_cnt + 16'd1;
        pready   <= 1'b0;
        pslverr  <= 1'b0;
      end
      if (do_abort) begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
      end
      if (do_abort || idle_err) proto_err <= 1'b1;
    end
  end

  // Write lands on the completion edge only; reset drops it.
  logic sram_we, sram_re;
  assign sram_we = do_done && wr_l && !bad_l && !rst;
  assign sram_re = do_setup && !pwrite && !bad && !rst;

  apb_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_WIDTH  (DATA_WIDTH),
    .IDX_W       (IDX_W)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .waddr (idx_l),
    .wdata (wdata_l),
    .re    (sram_re),
    .raddr (idx),
    .rdata (sram_rdata)
  );

  assign prdata = rd_sel ? sram_rdata : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (WAIT_CYCLES=0 and 2) on separate
// APB buses; expected responses are queued when a transfer starts and
// compared when pready is seen.
module tb_apb_slave_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        psel[2], penable[2], pwrite[2];
  logic [31:0] paddr[2], pwdata[2], prdata[2];
  logic        pready[2], pslverr[2], proto_err[2];
  logic [15:0] xfer_cnt[2];

  apb_slave_mem #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .proto_err(proto_err[0]), .xfer_cnt(xfer_cnt[0])
  );

  apb_slave_mem #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .proto_err(proto_err[1]), .xfer_cnt(xfer_cnt[1])
  );

  typedef struct {
    bit          chk;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus(input int d);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    pwrite[d]  = 1'b0;
    paddr[d]   = '0;
    pwdata[d]  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One complete transfer; returns with the bus idle right after the
  // completion edge so a following call starts back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input bit chk, input logic [31:0] exp_d, input logic exp_e,
                      output int ncyc, output int nlow);
    exp_t e;
    bit   done;
    e.chk = chk; e.data = exp_d; e.err = exp_e;
    sb.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
    tick();
    penable[d] = 1'b1;
    ncyc = 1;
    nlow = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      ncyc++;
      if (pready[d] === 1'b1) begin
        e = sb.pop_front();
        nvec++;
        if (pslverr[d] !== e.err) begin
          nerr++;
          $display("FAIL pslverr d%0d @%h: got %b want %b", d, addr, pslverr[d], e.err);
        end
        if (e.chk) begin
          nvec++;
          if (prdata[d] !== e.data) begin
            nerr++;
            $display("FAIL prdata d%0d @%h: got %h want %h", d, addr, prdata[d], e.data);
          end
        end
        done = 1;
      end else begin
        nlow++;
      end
      tick();
    end
    if (!done) begin
      nvec++;
      nerr++;
      $display("FAIL timeout d%0d @%h: no pready within 20 cycles", d, addr);
      e = sb.pop_front();
    end
    idle_bus(d);
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      nvec++; if (prdata[d] !== 32'h0) begin nerr++; $display("FAIL reset_prdata d%0d: got %h want 0", d, prdata[d]); end
      nvec++; if (pready[d] !== 1'b0) begin nerr++; $display("FAIL reset_pready d%0d: got %b want 0", d, pready[d]); end
      nvec++; if (pslverr[d] !== 1'b0) begin nerr++; $display("FAIL reset_pslverr d%0d: got %b want 0", d, pslverr[d]); end
      nvec++; if (proto_err[d] !== 1'b0) begin nerr++; $display("FAIL reset_proto d%0d: got %b want 0", d, proto_err[d]); end
      nvec++; if (xfer_cnt[d] !== 16'd0) begin nerr++; $display("FAIL reset_cnt d%0d: got %0d want 0", d, xfer_cnt[d]); end
    end
  endtask

  task automatic test_no_wait();
    int nc, nl;
    xfer(0, 1'b1, 32'h0002_F004, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, nc, nl);
    nvec++; if (nc !== 2) begin nerr++; $display("FAIL nowait_wr_cycles: got %0d want 2", nc); end
    xfer(0, 1'b0, 32'h0002_F004, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, nc, nl);
    nvec++; if (nc !== 2) begin nerr++; $display("FAIL nowait_rd_cycles: got %0d want 2", nc); end
    nvec++; if (xfer_cnt[0] !== 16'd2) begin nerr++; $display("FAIL nowait_cnt: got %0d want 2", xfer_cnt[0]); end
  endtask

  task automatic test_wait();
    int nc, nl;
    xfer(1, 1'b1, 32'h0002_F004, 32'hCAFE_0001, 1'b0, 32'h0, 1'b0, nc, nl);
    xfer(1, 1'b0, 32'h0002_F004, 32'h0, 1'b1, 32'hCAFE_0001, 1'b0, nc, nl);
    nvec++; if (nc !== 4) begin nerr++; $display("FAIL wait_cycles: got %0d want 4", nc); end
    nvec++; if (nl !== 2) begin nerr++; $display("FAIL wait_low: got %0d want 2", nl); end
  endtask

  task automatic test_errors();
    int nc, nl;
    xfer(1, 1'b1, 32'h0002_F000, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0, nc, nl);
    xfer(1, 1'b1, 32'h0002_E000, 32'h1234_5678, 1'b1, 32'h0, 1'b1, nc, nl);
    xfer(1, 1'b0, 32'h0002_F002, 32'h0, 1'b1, 32'h0, 1'b1, nc, nl);
    xfer(1, 1'b0, 32'h0002_F000, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0, nc, nl);
    // first byte past the window
    xfer(1, 1'b0, 32'h0003_0000, 32'h0, 1'b1, 32'h0, 1'b1, nc, nl);
    // last word of the window
    xfer(1, 1'b1, 32'h0002_FFFC, 32'h0000_FFFC, 1'b0, 32'h0, 1'b0, nc, nl);
    xfer(1, 1'b0, 32'h0002_FFFC, 32'h0, 1'b1, 32'h0000_FFFC, 1'b0, nc, nl);
  endtask

  task automatic test_back_to_back();
    int nc, nl, t0;
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 4; i++)
      xfer(1, 1'b1, 32'h0002_F000 + 32'(4*i), 32'(i+1), 1'b0, 32'h0, 1'b0, nc, nl);
    nvec++; if (cyc - t0 !== 16) begin nerr++; $display("FAIL b2b_cycles: got %0d want 16", cyc - t0); end
    for (int i = 0; i < 4; i++)
      xfer(1, 1'b0, 32'h0002_F000 + 32'(4*i), 32'h0, 1'b1, 32'(i+1), 1'b0, nc, nl);
    nvec++; if (xfer_cnt[1] !== 16'd8) begin nerr++; $display("FAIL b2b_cnt: got %0d want 8", xfer_cnt[1]); end
  endtask

  task automatic test_proto();
    int nc, nl;
    logic [15:0] cnt0;
    cnt0 = xfer_cnt[1];
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h0002_F008; pwdata[1] = 32'h77;
    tick();
    penable[1] = 1'b1;
    tick();
    psel[1] = 1'b0;
    tick();
    idle_bus(1);
    nvec++; if (proto_err[1] !== 1'b1) begin nerr++; $display("FAIL proto_drop: got %b want 1", proto_err[1]); end
    nvec++; if (pready[1] !== 1'b0) begin nerr++; $display("FAIL proto_pready: got %b want 0", pready[1]); end
    nvec++; if (xfer_cnt[1] !== cnt0) begin nerr++; $display("FAIL proto_cnt: got %0d want %0d", xfer_cnt[1], cnt0); end
    tick();
    xfer(1, 1'b0, 32'h0002_F008, 32'h0, 1'b1, 32'h3, 1'b0, nc, nl);
    nvec++; if (proto_err[1] !== 1'b1) begin nerr++; $display("FAIL proto_sticky: got %b want 1", proto_err[1]); end
    do_reset();
    nvec++; if (proto_err[1] !== 1'b0) begin nerr++; $display("FAIL proto_clr: got %b want 0", proto_err[1]); end
    penable[1] = 1'b1;
    tick();
    penable[1] = 1'b0;
    nvec++; if (proto_err[1] !== 1'b1) begin nerr++; $display("FAIL proto_idle_pen: got %b want 1", proto_err[1]); end
  endtask

  task automatic test_reset_midwrite();
    int nc, nl;
    xfer(1, 1'b1, 32'h0002_F010, 32'h5555_5555, 1'b0, 32'h0, 1'b0, nc, nl);
    xfer(1, 1'b0, 32'h0002_F010, 32'h0, 1'b1, 32'h5555_5555, 1'b0, nc, nl);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h0002_F010; pwdata[1] = 32'hAAAA_AAAA;
    tick();
    penable[1] = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_bus(1);
    nvec++; if (prdata[1] !== 32'h0) begin nerr++; $display("FAIL midrst_prdata: got %h want 0", prdata[1]); end
    nvec++; if (pready[1] !== 1'b0) begin nerr++; $display("FAIL midrst_pready: got %b want 0", pready[1]); end
    nvec++; if (pslverr[1] !== 1'b0) begin nerr++; $display("FAIL midrst_pslverr: got %b want 0", pslverr[1]); end
    nvec++; if (proto_err[1] !== 1'b0) begin nerr++; $display("FAIL midrst_proto: got %b want 0", proto_err[1]); end
    nvec++; if (xfer_cnt[1] !== 16'd0) begin nerr++; $display("FAIL midrst_cnt: got %0d want 0", xfer_cnt[1]); end
    tick();
    xfer(1, 1'b0, 32'h0002_F010, 32'h0, 1'b1, 32'h5555_5555, 1'b0, nc, nl);
  endtask

  initial begin
    rst = 1'b1;
    idle_bus(0);
    idle_bus(1);
    tick();
    test_reset();
    test_no_wait();
    test_wait();
    test_errors();
    test_back_to_back();
    test_proto();
    test_reset_midwrite();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
